// File: rtl/rd_alu_pkg.sv
// rtl/rd_alu_pkg.sv - shared types and decode helpers for the ALU execute stage
//
// Purpose: ALUOp encoding, 4-bit ALU control codes ({funct7[5], funct3}),
// FSM states and small decode helpers used by rd_alu_decode and rd_alu_exec_unit.
// Ports: none (package).
package rd_alu_pkg;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_ctrl_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // True for the ten {funct7[5], funct3} codes an R-type instruction may carry.
    function automatic logic is_rtype_code(input logic [3:0] code);
        case (code)
            4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_shift_op(input alu_ctrl_e ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/rd_alu_decode.sv
// rtl/rd_alu_decode.sv - combinational ALUOp/funct to ALU control decoder
//
// Purpose: maps ALUOp and {funct7[5], funct3} onto a 4-bit ALU control code and
// flags undecodable combinations. Purely combinational so other stages can reuse it.
// Ports:
//   alu_op_i   in  2  ALUOp (00 load/store, 01 branch, 10 R-type, 11 I-type)
//   funct_i    in  4  {funct7[5], funct3}
//   ctrl_o     out 4  ALU control code (ADD when illegal)
//   illegal_o  out 1  combination cannot be decoded
module rd_alu_decode
    import rd_alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [3:0] funct_i,
    output logic [3:0] ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = ALU_ADD;
        illegal_o = 1'b0;
        case (alu_op_e'(alu_op_i))
            ALUOP_MEM:    ctrl_o = ALU_ADD;
            ALUOP_BRANCH: ctrl_o = ALU_SUB;
            ALUOP_RTYPE: begin
                if (is_rtype_code(funct_i)) begin
                    ctrl_o = funct_i;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            ALUOP_ITYPE: begin
                // Immediates have no funct7, so bit 30 is only meaningful for SRAI;
                // a set bit 30 on SLLI is a malformed encoding.
                if (funct_i == 4'b1001) begin
                    illegal_o = 1'b1;
                end else if (funct_i[2:0] == 3'b101) begin
                    ctrl_o = funct_i;
                end else begin
                    ctrl_o = {1'b0, funct_i[2:0]};
                end
            end
            default: ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rd_alu_exec_unit.sv
// rtl/rd_alu_exec_unit.sv - ALU execute stage with iterative shifter and valid/ready handshake
//
// Purpose: decodes ALUOp/funct, executes on XLEN operands and presents a single held
// result. Non-shift ops take one cycle; shifts advance SHIFT_STEP bits per cycle.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   flush_i                    abort in-flight op and drop held result
//   in_valid_i / in_ready_o    input handshake
//   alu_op_i, funct_i          ALUOp and {funct7[5], funct3}
//   op_a_i, op_b_i             operands (op_b_i may carry an immediate)
//   out_valid_o / out_ready_i  output handshake
//   result_o, zero_o           result and result==0 flag
//   illegal_o                  undecodable op, qualified by out_valid_o
module rd_alu_exec_unit
    import rd_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      alu_op_i,
    input  logic [3:0]      funct_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam int SHW = $clog2(XLEN);
    // One extra bit so the step size itself (up to XLEN) fits in the counter width.
    localparam int CW = SHW + 1;
    localparam logic [CW-1:0]   STEP = CW'(SHIFT_STEP);
    localparam logic [XLEN-1:0] ONES = '1;

    logic [3:0] dec_ctrl_raw;
    logic       dec_illegal;
    alu_ctrl_e  dec_ctrl;

    rd_alu_decode u_decode (
        .alu_op_i  (alu_op_i),
        .funct_i   (funct_i),
        .ctrl_o    (dec_ctrl_raw),
        .illegal_o (dec_illegal)
    );

    assign dec_ctrl = alu_ctrl_e'(dec_ctrl_raw);

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            sign_q, sign_d;
    alu_ctrl_e       sh_op_q, sh_op_d;

    logic [SHW-1:0]  shamt;
    logic            accept;
    logic            start_shift;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] issue_res;
    logic [CW-1:0]   step_amt;
    logic [XLEN-1:0] shifted;

    assign shamt       = op_b_i[SHW-1:0];
    assign in_ready_o  = (state_q == IDLE) && (!out_valid_q || out_ready_i);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign start_shift = !dec_illegal && is_shift_op(dec_ctrl) && (shamt != '0);
    assign issue_res   = dec_illegal ? '0 : alu_res;

    // Single-cycle result; a shift only reaches here with shamt 0, where it is op_a_i.
    always_comb begin
        alu_res = op_a_i;
        case (dec_ctrl)
            ALU_ADD:  alu_res = op_a_i + op_b_i;
            ALU_SUB:  alu_res = op_a_i - op_b_i;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
            ALU_XOR:  alu_res = op_a_i ^ op_b_i;
            ALU_OR:   alu_res = op_a_i | op_b_i;
            ALU_AND:  alu_res = op_a_i & op_b_i;
            default:  alu_res = op_a_i;
        endcase
    end

    // One shifter iteration: move by min(SHIFT_STEP, remaining).
    assign step_amt = (rem_q > STEP) ? STEP : rem_q;

    always_comb begin
        shifted = shreg_q >> step_amt;
        if (sh_op_q == ALU_SLL) begin
            shifted = shreg_q << step_amt;
        end else if (sh_op_q == ALU_SRA && sign_q) begin
            shifted = (shreg_q >> step_amt) | ~(ONES >> step_amt);
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        shreg_d     = shreg_q;
        rem_d       = rem_q;
        sign_d      = sign_q;
        sh_op_d     = sh_op_q;

        // Consumer took the result; data stays on result_o but is no longer valid.
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (start_shift) begin
                        state_d = SHIFT;
                        shreg_d = op_a_i;
                        rem_d   = {1'b0, shamt};
                        sign_d  = op_a_i[XLEN-1];
                        sh_op_d = dec_ctrl;
                    end else begin
                        result_d    = issue_res;
                        zero_d      = (issue_res == '0);
                        illegal_d   = dec_illegal;
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                rem_d   = rem_q - step_amt;
                // Final iteration publishes directly so the result is visible next cycle.
                if (rem_q <= STEP) begin
                    state_d     = IDLE;
                    result_d    = shifted;
                    zero_d      = (shifted == '0);
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush beats everything, but the last visible result value is kept.
        if (flush_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
            result_d    = result_q;
            zero_d      = zero_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            shreg_q     <= '0;
            rem_q       <= '0;
            sign_q      <= 1'b0;
            sh_op_q     <= ALU_SLL;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            shreg_q     <= shreg_d;
            rem_q       <= rem_d;
            sign_q      <= sign_d;
            sh_op_q     <= sh_op_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign zero_o      = zero_q;
    assign illegal_o   = illegal_q;

endmodule
